// File: rtl/fec_rx_pkt_ctrl.sv
// Packet-level sequencer for the FEC receive chain.
// Issues the decoder start pulse, accepts the header length, steers decoded bytes
// into the RX packet buffer and closes each packet with one done pulse and status.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------------
//  IDLE     | no packet in flight; waits for pkt_start (or one latched in DONE)
//  WAIT_HDR | decoder started, waiting for a header length; timer running
//  DATA     | payload bytes forwarded to the RX buffer; timer running
//  DONE     | single cycle: rx_done pulse, rx_status valid
module fec_rx_pkt_ctrl #(
    parameter int TIMEOUT_CYC = 262144,
    parameter int MAX_NBYTE   = 16383,
    parameter int ACK_NBYTE   = 24
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pkt_start_i,
    input  logic        hdr_vld_i,
    input  logic [13:0] hdr_nbyte_i,
    input  logic        dec_we_i,
    input  logic [7:0]  dec_byte_i,
    output logic        dec_start_o,
    output logic        in_dec_o,
    output logic        buf_we_o,
    output logic [13:0] buf_addr_o,
    output logic [7:0]  buf_data_o,
    output logic        rx_done_o,
    output logic [1:0]  rx_status_o,
    output logic        ack_pkt_o
);

    typedef enum logic [1:0] {IDLE, WAIT_HDR, DATA, DONE} state_e;

    localparam logic [23:0] TIMER_TC = 24'(TIMEOUT_CYC - 1);
    localparam logic [1:0]  ST_OK    = 2'b00;
    localparam logic [1:0]  ST_TMO   = 2'b01;
    localparam logic [1:0]  ST_HERR  = 2'b10;

    state_e      state_q, state_d;
    logic [13:0] byte_cnt_q, byte_cnt_d;
    logic [13:0] nbyte_q, nbyte_d;
    logic [23:0] timer_q, timer_d;
    logic        dec_start_q, dec_start_d;
    logic        rx_done_q, rx_done_d;
    logic [1:0]  rx_status_q, rx_status_d;
    logic        ack_pkt_q, ack_pkt_d;
    logic        start_pend_q, start_pend_d;

    logic        start_now;
    logic        finish;
    logic [1:0]  fin_status;
    logic        hdr_ok;
    logic        last_wr;
    logic        timer_tc;
    logic        in_data;

    assign hdr_ok   = (hdr_nbyte_i != 14'd0) && (int'(hdr_nbyte_i) <= MAX_NBYTE);
    assign last_wr  = dec_we_i && (byte_cnt_q == (nbyte_q - 14'd1));
    assign timer_tc = (timer_q == TIMER_TC);
    assign in_data  = (state_q == DATA);

    // Buffer port is transparent to the decoder only while a payload is being accepted.
    assign buf_we_o    = in_data && dec_we_i;
    assign buf_addr_o  = in_data ? byte_cnt_q : 14'd0;
    assign buf_data_o  = in_data ? dec_byte_i : 8'd0;
    assign in_dec_o    = (state_q == WAIT_HDR) || (state_q == DATA);
    assign dec_start_o = dec_start_q;
    assign rx_done_o   = rx_done_q;
    assign rx_status_o = rx_status_q;
    assign ack_pkt_o   = ack_pkt_q;

    // Next-state logic: packet progress, termination cause and restart handling.
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        nbyte_d      = nbyte_q;
        timer_d      = timer_q;
        dec_start_d  = 1'b0;
        rx_done_d    = 1'b0;
        rx_status_d  = rx_status_q;
        ack_pkt_d    = ack_pkt_q;
        start_pend_d = start_pend_q;
        start_now    = 1'b0;
        finish       = 1'b0;
        fin_status   = ST_OK;

        case (state_q)
            IDLE: begin
                if (pkt_start_i || start_pend_q) start_now = 1'b1;
            end
            WAIT_HDR: begin
                if (pkt_start_i) begin
                    start_now = 1'b1;
                end else if (hdr_vld_i) begin
                    if (hdr_ok) begin
                        nbyte_d   = hdr_nbyte_i;
                        ack_pkt_d = (int'(hdr_nbyte_i) == ACK_NBYTE);
                        state_d   = DATA;
                        if (!timer_tc) timer_d = timer_q + 24'd1;
                    end else begin
                        finish     = 1'b1;
                        fin_status = ST_HERR;
                    end
                end else if (timer_tc) begin
                    finish     = 1'b1;
                    fin_status = ST_TMO;
                end else begin
                    timer_d = timer_q + 24'd1;
                end
            end
            DATA: begin
                // Completion is checked before timeout so a final write on the
                // terminal cycle still reports OK.
                if (pkt_start_i) begin
                    start_now = 1'b1;
                end else if (last_wr) begin
                    finish     = 1'b1;
                    fin_status = ST_OK;
                end else if (timer_tc) begin
                    finish     = 1'b1;
                    fin_status = ST_TMO;
                end else begin
                    timer_d = timer_q + 24'd1;
                    if (dec_we_i) byte_cnt_d = byte_cnt_q + 14'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (pkt_start_i) start_pend_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (finish) begin
            state_d     = DONE;
            rx_done_d   = 1'b1;
            rx_status_d = fin_status;
        end

        if (start_now) begin
            state_d      = WAIT_HDR;
            dec_start_d  = 1'b1;
            timer_d      = 24'd0;
            byte_cnt_d   = 14'd0;
            nbyte_d      = 14'd0;
            ack_pkt_d    = 1'b0;
            start_pend_d = 1'b0;
        end
    end

    // State and registered outputs; reset overrides everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            byte_cnt_q   <= 14'd0;
            nbyte_q      <= 14'd0;
            timer_q      <= 24'd0;
            dec_start_q  <= 1'b0;
            rx_done_q    <= 1'b0;
            rx_status_q  <= ST_OK;
            ack_pkt_q    <= 1'b0;
            start_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            nbyte_q      <= nbyte_d;
            timer_q      <= timer_d;
            dec_start_q  <= dec_start_d;
            rx_done_q    <= rx_done_d;
            rx_status_q  <= rx_status_d;
            ack_pkt_q    <= ack_pkt_d;
            start_pend_q <= start_pend_d;
        end
    end

endmodule

// File: tb/tb_fec_rx_pkt_ctrl.sv
// Bench for fec_rx_pkt_ctrl: vector table, directed corner sequences and a
// randomized run against a packet-level reference model.
module tb_fec_rx_pkt_ctrl;

    localparam int T_CYC = 64;
    localparam int MAXN  = 100;
    localparam int ACKN  = 24;

    logic        clk_i = 1'b0;
    logic        rst_i, pkt_start_i, hdr_vld_i, dec_we_i;
    logic [13:0] hdr_nbyte_i;
    logic [7:0]  dec_byte_i;
    logic        dec_start_o, in_dec_o, buf_we_o, rx_done_o, ack_pkt_o;
    logic [13:0] buf_addr_o;
    logic [7:0]  buf_data_o;
    logic [1:0]  rx_status_o;

    int n_chk  = 0;
    int n_fail = 0;

    fec_rx_pkt_ctrl #(.TIMEOUT_CYC(T_CYC), .MAX_NBYTE(MAXN), .ACK_NBYTE(ACKN)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .pkt_start_i(pkt_start_i), .hdr_vld_i(hdr_vld_i),
        .hdr_nbyte_i(hdr_nbyte_i), .dec_we_i(dec_we_i), .dec_byte_i(dec_byte_i),
        .dec_start_o(dec_start_o), .in_dec_o(in_dec_o), .buf_we_o(buf_we_o),
        .buf_addr_o(buf_addr_o), .buf_data_o(buf_data_o), .rx_done_o(rx_done_o),
        .rx_status_o(rx_status_o), .ack_pkt_o(ack_pkt_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // {dec_start, in_dec, buf_we, buf_addr, buf_data, rx_done, rx_status, ack_pkt}
    function automatic logic [28:0] obs();
        return {dec_start_o, in_dec_o, buf_we_o, buf_addr_o, buf_data_o, rx_done_o, rx_status_o, ack_pkt_o};
    endfunction

    function automatic logic [28:0] pk(input bit ds, input bit ind, input bit we, input int addr,
                                       input logic [7:0] data, input bit done, input logic [1:0] st,
                                       input bit ack);
        return {ds, ind, we, 14'(addr), data, done, st, ack};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs away from the active edge and let outputs settle.
    task automatic cyc(input bit r, input bit ps, input bit hv, input logic [13:0] hn,
                       input bit we, input logic [7:0] db);
        @(negedge clk_i);
        rst_i = r; pkt_start_i = ps; hdr_vld_i = hv; hdr_nbyte_i = hn;
        dec_we_i = we; dec_byte_i = db;
        #1;
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("reset_outputs", 32'(obs()), 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          r, ps, hv, we;
        logic [13:0] hn;
        logic [7:0]  db;
        logic [28:0] exp;
    } vec_t;
    vec_t vec[$];

    function automatic vec_t mk(input bit r, input bit ps, input bit hv, input int hn, input bit we,
                                input logic [7:0] db, input logic [28:0] exp);
        vec_t v;
        v.r = r; v.ps = ps; v.hv = hv; v.hn = 14'(hn); v.we = we; v.db = db; v.exp = exp;
        return v;
    endfunction

    // ---------------- reference model ----------------
    bit          m_busy, m_hdr, m_done, m_first, m_pend, m_ack;
    int          m_len, m_cnt, m_age;
    logic [1:0]  m_status;

    task automatic model_reset();
        m_busy = 0; m_hdr = 0; m_done = 0; m_first = 0; m_pend = 0; m_ack = 0;
        m_len = 0; m_cnt = 0; m_age = 0; m_status = 2'b00;
    endtask

    function automatic logic [28:0] model_out(input bit we, input logic [7:0] db);
        bit acc;
        acc = m_busy && m_hdr;
        return pk(m_first, m_busy, acc && we, acc ? m_cnt : 0, acc ? db : 8'd0, m_done, m_status, m_ack);
    endfunction

    task automatic model_end(input logic [1:0] st);
        m_busy = 0; m_hdr = 0; m_done = 1; m_status = st;
    endtask

    task automatic model_step(input bit r, input bit ps, input bit hv, input int hn, input bit we);
        if (r) begin
            model_reset();
        end else begin
            m_first = 0;
            if (m_done) begin
                m_done = 0;
                if (ps) m_pend = 1;
            end else if ((m_busy && ps) || (!m_busy && (ps || m_pend))) begin
                m_busy = 1; m_hdr = 0; m_first = 1; m_pend = 0;
                m_cnt = 0; m_age = 0; m_ack = 0;
            end else if (m_busy) begin
                if (!m_hdr && hv) begin
                    if (hn >= 1 && hn <= MAXN) begin
                        m_hdr = 1; m_len = hn; m_ack = (hn == ACKN);
                    end else begin
                        model_end(2'b10);
                    end
                end else if (m_hdr && we && (m_cnt + 1 == m_len)) begin
                    model_end(2'b00);
                end else if (m_age == T_CYC - 1) begin
                    model_end(2'b01);
                end else if (m_hdr && we) begin
                    m_cnt++;
                end
                if (m_age < T_CYC - 1) m_age++;
            end
        end
    endtask

    // Final write landing on the terminal timer cycle: completion must win.
    task automatic tmo_race(input int len, input logic [1:0] exp_st, input string name);
        do_reset();
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 14'(len), 0, 0);
        for (int i = 0; i < T_CYC - 2; i++) cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 8'h3C);
        chk({name, "_wr"}, 32'({buf_we_o, buf_addr_o}), 32'({1'b1, 14'd0}));
        cyc(0, 0, 0, 0, 0, 0);
        chk({name, "_done"}, 32'({rx_done_o, rx_status_o}), 32'({1'b1, exp_st}));
    endtask

    int          cnt_done, cnt_we, n_lat, we_pct, k;
    logic [1:0]  st_seen;
    bit          rr, rps, rhv, rwe;
    logic [13:0] rhn;
    logic [7:0]  rdb;

    initial begin
        rst_i = 1; pkt_start_i = 0; hdr_vld_i = 0; hdr_nbyte_i = 0; dec_we_i = 0; dec_byte_i = 0;

        // nbyte=5 packet, header error (0 and >MAX), pkt_start latched in DONE,
        // hdr_vld ignored in DATA, reset mid-DATA and restart.
        vec.push_back(mk(0,1,0,0,  0,8'h00, pk(0,0,0,0,8'h00,0,2'b00,0)));
        vec.push_back(mk(0,0,0,0,  0,8'h00, pk(1,1,0,0,8'h00,0,2'b00,0)));
        vec.push_back(mk(0,0,1,5,  1,8'h55, pk(0,1,0,0,8'h00,0,2'b00,0)));
        vec.push_back(mk(0,0,0,0,  1,8'hA0, pk(0,1,1,0,8'hA0,0,2'b00,0)));
        vec.push_back(mk(0,0,0,0,  0,8'h00, pk(0,1,0,1,8'h00,0,2'b00,0)));
        vec.push_back(mk(0,0,0,0,  1,8'hA1, pk(0,1,1,1,8'hA1,0,2'b00,0)));
        vec.push_back(mk(0,0,0,0,  1,8'hA2, pk(0,1,1,2,8'hA2,0,2'b00,0)));
        vec.push_back(mk(0,0,0,0,  1,8'hA3, pk(0,1,1,3,8'hA3,0,2'b00,0)));
        vec.push_back(mk(0,0,0,0,  1,8'hA4, pk(0,1,1,4,8'hA4,0,2'b00,0)));
        vec.push_back(mk(0,0,0,0,  1,8'hA5, pk(0,0,0,0,8'h00,1,2'b00,0)));
        vec.push_back(mk(0,0,0,0,  0,8'h00, pk(0,0,0,0,8'h00,0,2'b00,0)));
        vec.push_back(mk(0,1,0,0,  0,8'h00, pk(0,0,0,0,8'h00,0,2'b00,0)));
        vec.push_back(mk(0,0,1,0,  1,8'h11, pk(1,1,0,0,8'h00,0,2'b00,0)));
        vec.push_back(mk(0,0,0,0,  0,8'h00, pk(0,0,0,0,8'h00,1,2'b10,0)));
        vec.push_back(mk(0,0,0,0,  0,8'h00, pk(0,0,0,0,8'h00,0,2'b10,0)));
        vec.push_back(mk(0,1,0,0,  0,8'h00, pk(0,0,0,0,8'h00,0,2'b10,0)));
        vec.push_back(mk(0,0,1,101,0,8'h00, pk(1,1,0,0,8'h00,0,2'b10,0)));
        vec.push_back(mk(0,1,0,0,  0,8'h00, pk(0,0,0,0,8'h00,1,2'b10,0)));
        vec.push_back(mk(0,0,0,0,  0,8'h00, pk(0,0,0,0,8'h00,0,2'b10,0)));
        vec.push_back(mk(0,0,1,24, 0,8'h00, pk(1,1,0,0,8'h00,0,2'b10,0)));
        vec.push_back(mk(0,0,1,7,  1,8'hB0, pk(0,1,1,0,8'hB0,0,2'b10,1)));
        vec.push_back(mk(1,0,0,0,  1,8'hB1, pk(0,1,1,1,8'hB1,0,2'b10,1)));
        vec.push_back(mk(0,0,0,0,  1,8'h77, pk(0,0,0,0,8'h00,0,2'b00,0)));
        vec.push_back(mk(0,1,0,0,  0,8'h00, pk(0,0,0,0,8'h00,0,2'b00,0)));
        vec.push_back(mk(0,0,0,0,  0,8'h00, pk(1,1,0,0,8'h00,0,2'b00,0)));

        do_reset();
        foreach (vec[i]) begin
            cyc(vec[i].r, vec[i].ps, vec[i].hv, vec[i].hn, vec[i].we, vec[i].db);
            chk($sformatf("vec%0d", i), 32'(obs()), 32'(vec[i].exp));
        end

        // ACK-length packet with gaps between bytes.
        do_reset();
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 14'(ACKN), 0, 0);
        chk("t2_dec_start", 32'(dec_start_o), 32'd1);
        for (int i = 0; i < ACKN; i++) begin
            if (i % 3 == 1) cyc(0, 0, 0, 0, 0, 0);
            cyc(0, 0, 0, 0, 1, 8'(8'hC0 + i));
            chk($sformatf("t2_wr%0d", i), 32'({buf_we_o, buf_addr_o, buf_data_o}),
                32'({1'b1, 14'(i), 8'(8'hC0 + i)}));
        end
        chk("t2_ack", 32'(ack_pkt_o), 32'd1);
        cnt_done = 0; cnt_we = 0; st_seen = 2'b11;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 1, 8'hFF);
            if (rx_done_o) begin cnt_done++; st_seen = rx_status_o; end
            if (buf_we_o) cnt_we++;
        end
        chk("t2_done_count", 32'(cnt_done), 32'd1);
        chk("t2_status", 32'(st_seen), 32'd0);
        chk("t2_overrun_we", 32'(cnt_we), 32'd0);

        // Header never arrives: timeout T_CYC cycles after dec_start.
        do_reset();
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 8'h5A);
        chk("t4_dec_start", 32'(dec_start_o), 32'd1);
        n_lat = 0;
        while (!rx_done_o && n_lat < 4 * T_CYC) begin
            cyc(0, 0, 0, 0, 1, 8'h5A);
            n_lat++;
        end
        chk("t4_latency", 32'(n_lat), 32'(T_CYC));
        chk("t4_status", 32'(rx_status_o), 32'd1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t4_in_dec_after", 32'(in_dec_o), 32'd0);

        // Abort mid-DATA and restart from address 0.
        do_reset();
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 10, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 8'(i));
        cnt_done = 0;
        cyc(0, 1, 0, 0, 0, 0);
        cnt_done += int'(rx_done_o);
        cyc(0, 0, 1, 4, 0, 0);
        cnt_done += int'(rx_done_o);
        chk("t5_restart", 32'({dec_start_o, in_dec_o}), 32'b11);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 1, 8'(8'hD0 + i));
            cnt_done += int'(rx_done_o);
            chk($sformatf("t5_addr%0d", i), 32'({buf_we_o, buf_addr_o}), 32'({1'b1, 14'(i)}));
        end
        chk("t5_no_done_abort", 32'(cnt_done), 32'd0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t5_done", 32'({rx_done_o, rx_status_o}), 32'b100);

        tmo_race(1, 2'b00, "race_last");
        tmo_race(2, 2'b01, "race_notlast");

        // Randomized run against the model.
        do_reset();
        model_reset();
        we_pct = 50;
        for (int c = 0; c < 5000; c++) begin
            rr  = ($urandom_range(0, 799) == 0);
            rps = ($urandom_range(0, 59) == 0);
            rhv = ($urandom_range(0, 7) == 0);
            k   = int'($urandom_range(0, 9));
            if (k == 0)      rhn = 14'd0;
            else if (k == 1) rhn = 14'($urandom_range(MAXN + 1, 16383));
            else             rhn = 14'($urandom_range(1, 30));
            rwe = ($urandom_range(0, 99) < we_pct);
            rdb = 8'($urandom);
            if (rps) we_pct = 10 + 40 * int'($urandom_range(0, 2));
            cyc(rr, rps, rhv, rhn, rwe, rdb);
            chk("rand", 32'(obs()), 32'(model_out(rwe, rdb)));
            model_step(rr, rps, rhv, int'(rhn), rwe);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
